terminal_uart_tx: RTL
=====================

# terminal_uart_tx

Board-side consumer of the processor's 8-bit output terminal. It detects every change of the terminal value, queues the new bytes in a small FIFO and serializes each one on a UART TX line (8N1, LSB first). It lets a host PC log the processor's output stream. It sits at the top level next to the processor, clocked by the undivided board clock, with its input wired to the processor's `out` port.

## Interface
- `CLKS_PER_BIT`, 434: clk cycles per UART bit (434 gives 115200 baud at 50 MHz). Must be ≥ 2.
- `FIFO_DEPTH`, 4: byte queue depth. Must be a power of two, ≥ 2.

- `clk` input 1: board clock; single clock domain; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `outTerminal` input 8: processor output terminal value, sampled every clk.
- `txd` output 1: UART serial line; idles high.
- `busy` output 1: high while a frame is in progress or the FIFO is non-empty.
- `fifoCount` output log2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte currently shifting out.
- `overflow` output 1: sticky; set when a change is dropped because the FIFO is full.

## Operation
- **Change detect.** Register `lastValue`, reset to 0x00. On each edge where `outTerminal != lastValue`:
  - `lastValue <= outTerminal`.
  - Push `outTerminal` into the FIFO. If the FIFO is full and no pop happens on the same edge, drop the byte, set `overflow` and still update `lastValue`.
- **Change definition.** A value held for many cycles is pushed once. Back-to-back distinct values on consecutive cycles are each pushed.
- **FIFO.** Circular, with write and read pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop is always legal, including when full: the count is unchanged and the pushed byte is accepted.
  - A pop when empty never occurs.
- **TX state machine:** IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) control it.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. On its last cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- `txd` is driven from a register; it has no combinational path from inputs.
- **Reset** (any time, including mid-frame): on the next edge, state goes to IDLE, `txd`=1, FIFO empties, `fifoCount`=0, `overflow`=0, `lastValue`=0x00, counters clear. Any partial frame is abandoned.
- After reset, a non-zero `outTerminal` counts as a change on the first non-reset edge and is transmitted.

## Timing
- **Reset values:** `txd`=1, `busy`=0, `fifoCount`=0, `overflow`=0.
- **Latency.** A change is present before edge k.
  - Edge k: push, `fifoCount`=1.
  - Edge k+1: IDLE pops, `fifoCount`=0, `txd` falls.
  - The start bit begins 2 edges after the change is first visible.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles. Back-to-back frames from a non-empty FIFO have a period of exactly 10·CLKS_PER_BIT cycles.
- **`busy`** rises on the push edge and falls on the edge that enters IDLE with the FIFO empty.
- **`overflow`** rises on the edge of the dropped push and holds until `rst`.
- **Throughput limit:** changes arriving faster than one per 10·CLKS_PER_BIT cycles, sustained, fill the FIFO. The processor's divided clock normally keeps the rate below this.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- **Reset state.** Hold `rst` 3 cycles with `outTerminal`=0x00, then release for 20 cycles. Required: `txd`=1, `busy`=0, `fifoCount`=0 throughout.
- **Single byte.** Step `outTerminal` 0x00→0xA5 and hold. Required:
  - `txd` low starting 2 edges later for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop bit high for 4 cycles.
  - Exactly one frame (40 cycles); `busy` then drops.
- **Burst and back-to-back.** Drive 0x01, 0x02, 0x03 on consecutive cycles. Required:
  - `fifoCount` peaks at 2.
  - Three contiguous frames with no idle gap (120 cycles total), decoded as 0x01, 0x02, 0x03.
- **Overflow.** Drive 7 distinct values on consecutive cycles. Required:
  - The first 5 are transmitted in order (1 shifting plus 4 queued).
  - Values 6 and 7 are dropped.
  - `overflow`=1 from the 6th push edge until `rst`.
- **Full plus pop.** Fill the FIFO while a frame ends, and present a new change on the STOP-last-cycle edge. Required: the byte is accepted, `fifoCount` is unchanged and `overflow` stays 0.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 of 0x5A. Required:
  - `txd`=1 and `fifoCount`=0 on the next edge.
  - After release with `outTerminal`=0x5A, one complete fresh 0x5A frame is sent.

Source files
------------

// File: rtl/terminal_uart_tx.sv
// Watches the processor's 8-bit output terminal, queues every new value in a small
// FIFO and streams each byte out as an 8N1 UART frame, LSB first.
module terminal_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    outTerminal,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic [7:0]      last_q, last_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            change;
  logic            bit_end;
  logic            fifo_nempty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            drop;

  // Serializer: pops the head byte from IDLE, or straight from the last STOP cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    pop         = 1'b0;
    bit_end     = (cnt_q == CW'(CLKS_PER_BIT - 1));
    fifo_nempty = (count_q != '0);
    fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
    case (state_q)
      IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (fifo_nempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is a function of the next state so txd comes straight off a flop
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Change detector and FIFO bookkeeping; a pop on the same edge frees a full slot
  always_comb begin
    change     = (outTerminal != last_q);
    push       = change && (!fifo_full || pop);
    drop       = change && fifo_full && !pop;
    last_d     = change ? outTerminal : last_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | drop;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      txd_q      <= 1'b1;
      last_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      txd_q      <= txd_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers and count
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= outTerminal;
    end
  end

  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) || fifo_nempty;
  assign fifoCount = count_q;
  assign overflow  = overflow_q;

endmodule
